// File: rtl/rs_pkg.sv
// Shared types and helpers for the reservation-station slice.
// Entry fields are sized for the widest supported configuration; instances truncate.
package rs_pkg;

  localparam int RS_MAX_DEPTH  = 16;
  localparam int RS_MAX_IDX_W  = 4;
  localparam int RS_MAX_DATA_W = 64;
  localparam int RS_MAX_ROB_W  = 8;
  localparam int RS_MAX_FUNC_W = 8;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    MUL = 4'd2,
    DIV = 4'd3,
    LD  = 4'd4,
    ST  = 4'd5,
    BEQ = 4'd6,
    BNE = 4'd7
  } rs_func_e;

  typedef struct packed {
    logic                     busy;
    logic [RS_MAX_FUNC_W-1:0] func;
    logic [RS_MAX_ROB_W-1:0]  rob;
    logic                     s1_rdy;
    logic [RS_MAX_DATA_W-1:0] s1;
    logic                     s2_rdy;
    logic [RS_MAX_DATA_W-1:0] s2;
  } rs_entry_t;

  // Lowest set index of vec; 0 when vec is empty (callers qualify with |vec).
  function automatic logic [RS_MAX_IDX_W-1:0] ff1(input logic [RS_MAX_DEPTH-1:0] vec);
    logic [RS_MAX_IDX_W-1:0] idx;
    idx = {RS_MAX_IDX_W{1'b0}};
    for (int i = RS_MAX_DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = RS_MAX_IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rs_pick.sv
// Lowest-index priority encoder: reports whether any request is set and which one wins.
module rs_pick
  import rs_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  assign found = |req;
  assign idx   = W'(ff1(RS_MAX_DEPTH'(req)));

endmodule

// File: rtl/rs_wakeup_station.sv
// Reservation station: holds dispatched micro-ops, wakes operands from the CDB,
// and issues the lowest-index fully-ready entry to its functional unit.
module rs_wakeup_station
  import rs_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ROB_W  = 3,
  parameter int FUNC_W = 4
) (
  input  logic                       clk2,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [FUNC_W-1:0]          disp_func,
  input  logic [ROB_W-1:0]           disp_rob,
  input  logic                       disp_s1_rdy,
  input  logic [DATA_W-1:0]          disp_s1,
  input  logic                       disp_s2_rdy,
  input  logic [DATA_W-1:0]          disp_s2,
  input  logic                       cdb_valid,
  input  logic [ROB_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [FUNC_W-1:0]          iss_func,
  output logic [DATA_W-1:0]          iss_op1,
  output logic [DATA_W-1:0]          iss_op2,
  output logic [ROB_W-1:0]           iss_rob,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  rs_entry_t         ents [DEPTH];
  logic [DEPTH-1:0]  free_vec;
  logic [DEPTH-1:0]  ready_vec;
  logic              free_found;
  logic              ready_found;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  ready_idx;
  logic              disp_fire;
  logic              iss_fire;
  logic              s1_rdy_in;
  logic              s2_rdy_in;
  logic [DATA_W-1:0] s1_in;
  logic [DATA_W-1:0] s2_in;

  // Occupancy and readiness vectors, from registered state only.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i]  = ~ents[i].busy;
      ready_vec[i] = ents[i].busy & ents[i].s1_rdy & ents[i].s2_rdy;
    end
  end

  rs_pick #(.N(DEPTH), .W(IDX_W)) u_free_pick (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_pick #(.N(DEPTH), .W(IDX_W)) u_ready_pick (
    .req   (ready_vec),
    .found (ready_found),
    .idx   (ready_idx)
  );

  assign disp_ready = (count != CNT_W'(DEPTH));
  assign disp_fire  = disp_valid & disp_ready & free_found;
  assign iss_valid  = ready_found;
  assign iss_fire   = iss_valid & iss_ready;

  // Dispatch bypass: an operand whose producer is on the CDB this cycle is stored as a value.
  always_comb begin
    if (!disp_s1_rdy && cdb_valid && (disp_s1[ROB_W-1:0] == cdb_tag)) begin
      s1_rdy_in = 1'b1;
      s1_in     = cdb_data;
    end else begin
      s1_rdy_in = disp_s1_rdy;
      s1_in     = disp_s1;
    end
    if (!disp_s2_rdy && cdb_valid && (disp_s2[ROB_W-1:0] == cdb_tag)) begin
      s2_rdy_in = 1'b1;
      s2_in     = cdb_data;
    end else begin
      s2_rdy_in = disp_s2_rdy;
      s2_in     = disp_s2;
    end
  end

  // Issue port mux; data outputs are held at zero when nothing is ready.
  always_comb begin
    if (ready_found) begin
      iss_func = FUNC_W'(ents[ready_idx].func);
      iss_op1  = DATA_W'(ents[ready_idx].s1);
      iss_op2  = DATA_W'(ents[ready_idx].s2);
      iss_rob  = ROB_W'(ents[ready_idx].rob);
    end else begin
      iss_func = {FUNC_W{1'b0}};
      iss_op1  = {DATA_W{1'b0}};
      iss_op2  = {DATA_W{1'b0}};
      iss_rob  = {ROB_W{1'b0}};
    end
  end

  // Entry state and occupancy count; flush overrides dispatch, wakeup and issue.
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ents[i] <= '0;
      end
      count <= {CNT_W{1'b0}};
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ents[i].busy <= 1'b0;
      end
      count <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ents[i].busy) begin
          if (cdb_valid && !ents[i].s1_rdy && (ROB_W'(ents[i].s1) == cdb_tag)) begin
            ents[i].s1     <= RS_MAX_DATA_W'(cdb_data);
            ents[i].s1_rdy <= 1'b1;
          end
          if (cdb_valid && !ents[i].s2_rdy && (ROB_W'(ents[i].s2) == cdb_tag)) begin
            ents[i].s2     <= RS_MAX_DATA_W'(cdb_data);
            ents[i].s2_rdy <= 1'b1;
          end
          if (iss_fire && (ready_idx == IDX_W'(i))) begin
            ents[i].busy <= 1'b0;
          end
        end else if (disp_fire && (free_idx == IDX_W'(i))) begin
          ents[i] <= '{busy:   1'b1,
                       func:   RS_MAX_FUNC_W'(disp_func),
                       rob:    RS_MAX_ROB_W'(disp_rob),
                       s1_rdy: s1_rdy_in,
                       s1:     RS_MAX_DATA_W'(s1_in),
                       s2_rdy: s2_rdy_in,
                       s2:     RS_MAX_DATA_W'(s2_in)};
        end
      end
      count <= count + CNT_W'(disp_fire) - CNT_W'(iss_fire);
    end
  end

endmodule

// File: tb/tb_rs_wakeup_station.sv
// Bench for rs_wakeup_station: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an array-based behavioural model.
module tb_rs_wakeup_station;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int ROB_W  = 3;
  localparam int FUNC_W = 4;
  localparam int CNT_W  = 3;

  logic              clk2 = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              disp_valid;
  logic              disp_ready;
  logic [FUNC_W-1:0] disp_func;
  logic [ROB_W-1:0]  disp_rob;
  logic              disp_s1_rdy;
  logic [DATA_W-1:0] disp_s1;
  logic              disp_s2_rdy;
  logic [DATA_W-1:0] disp_s2;
  logic              cdb_valid;
  logic [ROB_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              iss_valid;
  logic              iss_ready;
  logic [FUNC_W-1:0] iss_func;
  logic [DATA_W-1:0] iss_op1;
  logic [DATA_W-1:0] iss_op2;
  logic [ROB_W-1:0]  iss_rob;
  logic [CNT_W-1:0]  count;

  always #5 clk2 = ~clk2;

  rs_wakeup_station #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W), .FUNC_W(FUNC_W)
  ) dut (
    .clk2(clk2), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_func(disp_func),
    .disp_rob(disp_rob), .disp_s1_rdy(disp_s1_rdy), .disp_s1(disp_s1),
    .disp_s2_rdy(disp_s2_rdy), .disp_s2(disp_s2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_func(iss_func),
    .iss_op1(iss_op1), .iss_op2(iss_op2), .iss_rob(iss_rob), .count(count)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: a bag of slots, each either empty or holding an op.
  bit                m_busy [DEPTH];
  logic [FUNC_W-1:0] m_func [DEPTH];
  logic [ROB_W-1:0]  m_rob  [DEPTH];
  bit                m_s1r  [DEPTH];
  logic [DATA_W-1:0] m_s1   [DEPTH];
  bit                m_s2r  [DEPTH];
  logic [DATA_W-1:0] m_s2   [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  function automatic int m_sel();
    for (int i = 0; i < DEPTH; i++) if (m_busy[i] && m_s1r[i] && m_s2r[i]) return i;
    return -1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int  sel;
    int  fr;
    bit  full;
    if (!rst_n || flush) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    end else begin
      sel  = m_sel();
      fr   = m_free();
      full = (m_count() == DEPTH);
      if (sel >= 0 && iss_ready) m_busy[sel] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_busy[i] && cdb_valid) begin
          if (!m_s1r[i] && m_s1[i][ROB_W-1:0] == cdb_tag) begin m_s1[i] = cdb_data; m_s1r[i] = 1'b1; end
          if (!m_s2r[i] && m_s2[i][ROB_W-1:0] == cdb_tag) begin m_s2[i] = cdb_data; m_s2r[i] = 1'b1; end
        end
      end
      if (disp_valid && !full && fr >= 0) begin
        m_busy[fr] = 1'b1;
        m_func[fr] = disp_func;
        m_rob[fr]  = disp_rob;
        if (!disp_s1_rdy && cdb_valid && disp_s1[ROB_W-1:0] == cdb_tag) begin
          m_s1r[fr] = 1'b1; m_s1[fr] = cdb_data;
        end else begin
          m_s1r[fr] = disp_s1_rdy; m_s1[fr] = disp_s1;
        end
        if (!disp_s2_rdy && cdb_valid && disp_s2[ROB_W-1:0] == cdb_tag) begin
          m_s2r[fr] = 1'b1; m_s2[fr] = cdb_data;
        end else begin
          m_s2r[fr] = disp_s2_rdy; m_s2[fr] = disp_s2;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk2 or negedge rst_n);
      model_step();
    end
  end

  // Cycle compare, on the falling edge when inputs and state are stable.
  initial begin
    forever begin
      @(negedge clk2);
      chk("count", 32'(count), 32'(m_count()));
      chk("disp_ready", 32'(disp_ready), (m_count() < DEPTH) ? 32'd1 : 32'd0);
      if (m_sel() >= 0) begin
        chk("iss_valid", 32'(iss_valid), 32'd1);
        chk("iss_func", 32'(iss_func), 32'(m_func[m_sel()]));
        chk("iss_op1", 32'(iss_op1), 32'(m_s1[m_sel()]));
        chk("iss_op2", 32'(iss_op2), 32'(m_s2[m_sel()]));
        chk("iss_rob", 32'(iss_rob), 32'(m_rob[m_sel()]));
      end else begin
        chk("iss_valid", 32'(iss_valid), 32'd0);
        chk("iss_func_idle", 32'(iss_func), 32'd0);
        chk("iss_op1_idle", 32'(iss_op1), 32'd0);
        chk("iss_op2_idle", 32'(iss_op2), 32'd0);
        chk("iss_rob_idle", 32'(iss_rob), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0; cdb_valid = 1'b0; iss_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic disp(input logic [FUNC_W-1:0] f, input logic [ROB_W-1:0] rob,
                      input logic r1, input logic [DATA_W-1:0] s1,
                      input logic r2, input logic [DATA_W-1:0] s2);
    disp_valid = 1'b1; disp_func = f; disp_rob = rob;
    disp_s1_rdy = r1; disp_s1 = s1; disp_s2_rdy = r2; disp_s2 = s2;
  endtask

  task automatic cdb(input logic [ROB_W-1:0] tag, input logic [DATA_W-1:0] data);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    disp_func = 4'd0; disp_rob = 3'd0; disp_s1_rdy = 1'b0; disp_s1 = 16'd0;
    disp_s2_rdy = 1'b0; disp_s2 = 16'd0; cdb_tag = 3'd0; cdb_data = 16'd0;
    tick(); tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_disp_ready", 32'(disp_ready), 32'd1);
    chk("rst_iss_valid", 32'(iss_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // ADD rob=2, 5 + 7
    disp(4'd0, 3'd2, 1'b1, 16'd5, 1'b1, 16'd7);
    tick(); idle();
    chk("add_valid", 32'(iss_valid), 32'd1);
    chk("add_op1", 32'(iss_op1), 32'd5);
    chk("add_op2", 32'(iss_op2), 32'd7);
    chk("add_rob", 32'(iss_rob), 32'd2);
    iss_ready = 1'b1;
    tick(); idle();
    chk("add_count_after", 32'(count), 32'd0);

    // MUL rob=1 waiting on tag 3
    disp(4'd2, 3'd1, 1'b0, 16'hF803, 1'b1, 16'd4);
    tick(); idle();
    chk("mul_waiting", 32'(iss_valid), 32'd0);
    cdb(3'd3, 16'd9);
    tick(); idle();
    chk("mul_valid", 32'(iss_valid), 32'd1);
    chk("mul_op1", 32'(iss_op1), 32'd9);
    chk("mul_op2", 32'(iss_op2), 32'd4);
    iss_ready = 1'b1;
    tick(); idle();

    // Dispatch bypass on s2
    disp(4'd1, 3'd3, 1'b1, 16'd1, 1'b0, 16'h0005);
    cdb(3'd5, 16'h00AA);
    tick(); idle();
    chk("byp_valid", 32'(iss_valid), 32'd1);
    chk("byp_op2", 32'(iss_op2), 32'h00AA);
    iss_ready = 1'b1;
    tick(); idle();

    // Fill with unresolved ops: entry i waits on tag 4+i
    for (int i = 0; i < DEPTH; i++) begin
      disp(4'(i), 3'(i), 1'b0, 16'hAB04 + 16'(i), 1'b1, 16'h0100 + 16'(i));
      tick();
    end
    idle();
    chk("full_count", 32'(count), 32'd4);
    chk("full_disp_ready", 32'(disp_ready), 32'd0);
    disp(4'd0, 3'd5, 1'b1, 16'd1, 1'b1, 16'd2);
    tick(); idle();
    chk("drop_count", 32'(count), 32'd4);
    chk("drop_no_issue", 32'(iss_valid), 32'd0);
    cdb(3'd6, 16'h1234);
    tick(); idle();
    chk("wake2_rob", 32'(iss_rob), 32'd2);
    chk("wake2_op1", 32'(iss_op1), 32'h1234);
    iss_ready = 1'b1;
    disp(4'd0, 3'd6, 1'b1, 16'd1, 1'b1, 16'd2);
    tick(); idle();
    chk("slot_count", 32'(count), 32'd3);
    chk("slot_disp_ready", 32'(disp_ready), 32'd1);

    // Entries 0 and 3 ready, stall then drain in order
    cdb(3'd4, 16'h0011); tick();
    cdb(3'd7, 16'h0033); tick(); idle();
    for (int k = 0; k < 3; k++) begin
      chk("hold_rob", 32'(iss_rob), 32'd0);
      chk("hold_op1", 32'(iss_op1), 32'h0011);
      tick();
    end
    iss_ready = 1'b1;
    tick();
    chk("second_rob", 32'(iss_rob), 32'd3);
    chk("second_op1", 32'(iss_op1), 32'h0033);
    tick(); idle();
    chk("drain_count", 32'(count), 32'd1);

    // Flush with three busy and a concurrent dispatch
    disp(4'd4, 3'd4, 1'b0, 16'h0001, 1'b1, 16'd0); tick();
    disp(4'd5, 3'd5, 1'b0, 16'h0002, 1'b1, 16'd0); tick(); idle();
    chk("preflush_count", 32'(count), 32'd3);
    flush = 1'b1;
    disp(4'd0, 3'd7, 1'b1, 16'd1, 1'b1, 16'd1);
    tick(); idle();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_iss_valid", 32'(iss_valid), 32'd0);
    tick();
    chk("flush_not_stored", 32'(iss_valid), 32'd0);

    // Asynchronous reset mid-operation
    disp(4'd0, 3'd6, 1'b1, 16'd3, 1'b1, 16'd4);
    tick(); idle();
    chk("pre_areset_valid", 32'(iss_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_count", 32'(count), 32'd0);
    chk("areset_iss_valid", 32'(iss_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int c = 0; c < 3000; c++) begin
      disp_valid  = ($urandom_range(99) < 60);
      disp_func   = 4'($urandom_range(7));
      disp_rob    = 3'($urandom);
      disp_s1_rdy = 1'($urandom_range(1));
      disp_s1     = 16'($urandom);
      disp_s2_rdy = 1'($urandom_range(1));
      disp_s2     = 16'($urandom);
      cdb_valid   = ($urandom_range(99) < 50);
      cdb_tag     = 3'($urandom);
      cdb_data    = 16'($urandom);
      iss_ready   = ($urandom_range(99) < 50);
      flush       = ($urandom_range(99) < 2);
      tick();
    end
    idle();
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rs_wakeup_station.md
Name: rs_wakeup_station

Overview:
- Parametrised reservation station. Successor to the fixed add/mul operand-append logic.
- Holds up to DEPTH dispatched micro-ops, each with two source operands. An operand holds either a value or a producer ROB tag.
- Snoops the common data bus (CDB) to wake pending operands, then issues one fully-ready entry per cycle to its functional unit.
- Sits between decode/rename and one functional unit. The design instantiates one per unit class (ALU, MUL/DIV, branch, LD/ST).

Parameters:
- DEPTH, 4, number of entries (2..16).
- DATA_W, 16, operand/result width.
- ROB_W, 3, ROB index/tag width.
- FUNC_W, 4, opcode width.

Ports:
- clk2  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries (mispredict).
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  station can accept; equals !full.
- disp_func  in  FUNC_W  opcode.
- disp_rob  in  ROB_W  destination ROB index.
- disp_s1_rdy  in  1  1 = disp_s1 is a value, 0 = disp_s1[ROB_W-1:0] is a producer tag.
- disp_s1  in  DATA_W  operand 1 value or tag.
- disp_s2_rdy  in  1  as disp_s1_rdy, for operand 2.
- disp_s2  in  DATA_W  as disp_s1, for operand 2.
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  ROB_W  producing ROB index.
- cdb_data  in  DATA_W  result value.
- iss_valid  out  1  entry issuing.
- iss_ready  in  1  functional unit accepts.
- iss_func  out  FUNC_W  opcode of the issuing entry.
- iss_op1  out  DATA_W  operand 1 of the issuing entry.
- iss_op2  out  DATA_W  operand 2 of the issuing entry.
- iss_rob  out  ROB_W  ROB index of the issuing entry.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Per-entry registers: busy, func, rob, s1_rdy, s1, s2_rdy, s2. Reset or flush clears every busy bit.
- Outputs on reset: disp_ready=1, iss_valid=0, count=0. iss_* data outputs are 0 while iss_valid=0.
- Dispatch:
  - Fires on disp_valid && disp_ready.
  - Writes the lowest-index free entry at the clock edge.
  - disp_valid while !disp_ready is ignored; nothing is written.
- Wakeup:
  - On cdb_valid, every busy entry with sN_rdy=0 and sN[ROB_W-1:0]==cdb_tag loads sN<=cdb_data and sets sN_rdy<=1.
  - Both operands of one entry may wake in the same cycle.
- Dispatch bypass: if a dispatching operand is a tag and matches cdb_tag while cdb_valid, the entry is written with the value and rdy=1. No result is lost.
- Readiness: an entry is ready when busy && s1_rdy && s2_rdy.
  - Readiness is computed from registered state only. A woken entry is issuable on the cycle after its wake edge; there is no CDB-to-issue combinational path.
- Issue select:
  - iss_valid = any ready entry. The lowest-index ready entry drives the iss_* outputs combinationally.
  - On iss_valid && iss_ready, that entry's busy bit clears at the edge.
  - While iss_ready=0, the selection may change only if a lower-index entry becomes ready.
- Full/empty:
  - full when count==DEPTH.
  - An issue in the same cycle does not make the slot available to dispatch; disp_ready is registered-state based.
  - Empty gives iss_valid=0.
- count: next = count + dispatch_fire − issue_fire. Dispatch and issue in the same cycle leaves count unchanged.
- flush: has priority over dispatch, wakeup and issue in the same cycle. count=0 next cycle. iss_valid is still computed combinationally during the flush cycle, but the fire is discarded.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge.
- Widths: a tag compare uses only the low ROB_W bits of the operand field; the upper bits are don't-care while rdy=0.

Decomposition:
- Shared package rs_pkg holds:
  - FUNC codes ADD=0, SUB=1, MUL=2, DIV=3, LD=4, ST=5, BEQ=6, BNE=7.
  - The rs_entry_t struct (busy, func, rob, s1_rdy, s1, s2_rdy, s2).
  - A function ff1(vec) returning the lowest set index.
- Sub-module rs_pick: a parametrised lowest-index priority encoder, outputs found + index. Instantiated twice: once for the free slot, once for the ready entry.

Test Plan:
- Reset release, then dispatch ADD rob=2 s1=val 5, s2=val 7 → iss_valid=1 next cycle with op1=5, op2=7, rob=2. After iss_ready, count returns to 0.
- Dispatch MUL rob=1 s1=tag 3, s2=val 4; then cdb_valid tag=3 data=9 → iss_valid rises on the cycle after the CDB edge with op1=9, op2=4.
- Dispatch with s2=tag 5 in the same cycle as cdb tag=5 data=0x00AA → entry stored ready; issues the next cycle with op2=0x00AA.
- Fill DEPTH=4 with operands unresolved → disp_ready=0 and count=4. A fifth disp_valid is dropped. Wake entry 2 and issue it → disp_ready=1 the next cycle.
- Entries 0 and 3 ready, iss_ready=0 for 3 cycles → iss_rob stays at entry 0's rob. iss_ready=1 → entry 0 issues first, then entry 3.
- flush with 3 busy entries and a concurrent dispatch → count=0, iss_valid=0 next cycle, and the dispatched op is not stored.
